// File: rtl/bcd_pkg.sv
// Shared constants for the iterative BCD-to-binary converter: state codes,
// work-register field layout and the input legality check.
package bcd_pkg;

    localparam int BIN_W         = 10;
    localparam int MAX_VAL       = 1023;
    localparam int BCD_DIGIT_MAX = 9;
    localparam int CNT_W         = $clog2(BIN_W);

    // Work register: {thousands, hundreds, tens, ones, binary accumulator}
    localparam int WORK_W        = BIN_W + 13;
    localparam int ONES_LSB      = BIN_W;
    localparam int TENS_LSB      = BIN_W + 4;
    localparam int HUNDREDS_LSB  = BIN_W + 8;
    localparam int THOUSANDS_BIT = BIN_W + 12;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // A digit above 9, or a decimal value above MAX_VAL, cannot be converted.
    function automatic logic bcd_invalid(
        input logic       thousands,
        input logic [3:0] hundreds,
        input logic [3:0] tens,
        input logic [3:0] ones
    );
        logic [10:0] value;
        logic        bad_digit;
        bad_digit = (hundreds > 4'(BCD_DIGIT_MAX)) ||
                    (tens     > 4'(BCD_DIGIT_MAX)) ||
                    (ones     > 4'(BCD_DIGIT_MAX));
        value = 11'(thousands) * 11'd1000 + 11'(hundreds) * 11'd100 +
                11'(tens) * 11'd10 + 11'(ones);
        return bad_digit || (value > 11'(MAX_VAL));
    endfunction

endpackage

// File: rtl/bcd_to_binary_ten_bit_seq_sub3.sv
// Per-digit correction for reverse double dabble: a nibble that landed at 8
// or above after the right shift gets 3 removed.
module sub3 (
    input  logic [3:0] nibble,
    output logic [3:0] fixed
);

    always_comb begin
        fixed = (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;
    end

endmodule

// File: rtl/bcd_to_binary_ten_bit_seq.sv
// Iterative 4-digit BCD (0..1023) to 10-bit binary converter; one shift per
// clock, result and error flag presented with a one-cycle done pulse.
module bcd_to_binary_ten_bit_seq
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ones,
    input  logic [3:0]       tens,
    input  logic [3:0]       hundreds,
    input  logic             thousands,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] bin
);

    logic [0:0]        state_reg;
    logic [WORK_W-1:0] work_reg;
    logic [WORK_W-1:0] work_shifted;
    logic [WORK_W-1:0] work_next;
    logic [CNT_W-1:0]  count_reg;
    logic              err_pend_reg;
    logic              done_reg;
    logic              err_reg;
    logic [BIN_W-1:0]  bin_reg;
    logic              input_bad;
    logic [3:0]        digit_fixed [3];

    assign work_shifted = work_reg >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sub3
            sub3 u_sub3 (
                .nibble (work_shifted[ONES_LSB + 4*gi +: 4]),
                .fixed  (digit_fixed[gi])
            );
        end
    endgenerate

    always_comb begin
        work_next = {work_shifted[THOUSANDS_BIT], digit_fixed[2], digit_fixed[1],
                     digit_fixed[0], work_shifted[BIN_W-1:0]};
    end

    assign input_bad = bcd_invalid(thousands, hundreds, tens, ones);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            work_reg     <= '0;
            count_reg    <= '0;
            err_pend_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            bin_reg      <= '0;
        end else begin
            done_reg <= 1'b0;

            // An invalid request was noted at the accept edge; report it now.
            if (err_pend_reg) begin
                done_reg     <= 1'b1;
                err_reg      <= 1'b1;
                bin_reg      <= '0;
                err_pend_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (input_bad) begin
                            err_pend_reg <= 1'b1;
                        end else begin
                            work_reg  <= {thousands, hundreds, tens, ones, {BIN_W{1'b0}}};
                            count_reg <= '0;
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg  <= work_next;
                    count_reg <= count_reg + CNT_W'(1);
                    if (count_reg == CNT_W'(BIN_W - 1)) begin
                        bin_reg   <= work_next[BIN_W-1:0];
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state_reg == ST_IDLE);
    assign done  = done_reg;
    assign err   = err_reg;
    assign bin   = bin_reg;

endmodule

// File: tb/tb_bcd_to_binary_ten_bit_seq.sv
// Directed-vector bench for the iterative BCD-to-binary converter, with
// hand-written mid-run start, mid-run reset and a full 0..1023 sweep.
module tb_bcd_to_binary_ten_bit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       thousands;
    logic       ready;
    logic       done;
    logic       err;
    logic [9:0] bin;

    int checks;
    int errors;

    bcd_to_binary_ten_bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .bin       (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       th;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [9:0] exp_bin;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Issue one request and wait for done; inputs are scrambled after accept.
    task automatic run_conv(input logic th, input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, output int lat, output logic [9:0] rbin,
                            output logic rerr, output logic rdy_at_done);
        int waits;
        waits = 0;
        @(negedge clk);
        while (!ready && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        if (!ready) check("ready_timeout", 0, 1);
        thousands = th; hundreds = h; tens = t; ones = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        thousands = 1'b1; hundreds = 4'hF; tens = 4'hF; ones = 4'hF;
        lat = 0;
        rdy_at_done = 1'b0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        rbin = bin;
        rerr = err;
        rdy_at_done = ready;
    endtask

    initial begin
        int         lat;
        logic [9:0] rbin;
        logic       rerr;
        logic       rdy;
        int         saw_done;
        int         ready_low;

        checks = 0;
        errors = 0;

        vecs[0] = '{"zero",      1'b0, 4'd0, 4'd0, 4'd0, 10'd0,    1'b0, 10};
        vecs[1] = '{"max_1023",  1'b1, 4'd0, 4'd2, 4'd3, 10'h3FF,  1'b0, 10};
        vecs[2] = '{"val_999",   1'b0, 4'd9, 4'd9, 4'd9, 10'd999,  1'b0, 10};
        vecs[3] = '{"val_42",    1'b0, 4'd0, 4'd4, 4'd2, 10'd42,   1'b0, 10};
        vecs[4] = '{"tens_A",    1'b0, 4'd0, 4'hA, 4'd0, 10'd0,    1'b1, 1};
        vecs[5] = '{"val_1024",  1'b1, 4'd0, 4'd2, 4'd4, 10'd0,    1'b1, 1};
        vecs[6] = '{"val_512",   1'b0, 4'd5, 4'd1, 4'd2, 10'd512,  1'b0, 10};
        vecs[7] = '{"th_h1",     1'b1, 4'd1, 4'd0, 4'd0, 10'd0,    1'b1, 1};

        rst_n = 1'b0; start = 1'b0;
        thousands = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", int'(ready), 1);
        check("reset_done",  int'(done),  0);
        check("reset_err",   int'(err),   0);
        check("reset_bin",   int'(bin),   0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_conv(vecs[i].th, vecs[i].h, vecs[i].t, vecs[i].o, lat, rbin, rerr, rdy);
            check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, "_bin"}, int'(rbin), int'(vecs[i].exp_bin));
            check({vecs[i].name, "_err"}, int'(rerr), int'(vecs[i].exp_err));
            check({vecs[i].name, "_ready_at_done"}, int'(rdy), 1);
            $display("vec %s lat=%0d bin=%0d err=%0d", vecs[i].name, lat, rbin, rerr);
        end

        // done must be a single-cycle pulse, and bin/err must hold afterwards
        run_conv(1'b0, 4'd1, 4'd2, 4'd3, lat, rbin, rerr, rdy);
        @(posedge clk); #1;
        check("done_pulse_width", int'(done), 0);
        check("bin_hold", int'(bin), 123);
        $display("pulse test bin=%0d", rbin);

        // start with new digits mid-run must be ignored
        @(negedge clk);
        thousands = 1'b0; hundreds = 4'd7; tens = 4'd0; ones = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ready_low = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (!ready) ready_low++;
        end
        check("ready_low_in_shift", ready_low, 3);
        @(negedge clk);
        thousands = 1'b0; hundreds = 4'd3; tens = 4'd3; ones = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check("midrun_start_lat", lat, 10);
        check("midrun_start_bin", int'(bin), 707);
        $display("midrun start bin=%0d lat=%0d", bin, lat);

        // asynchronous reset at count=5 discards the conversion
        @(negedge clk);
        thousands = 1'b0; hundreds = 4'd2; tens = 4'd5; ones = 4'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", int'(ready), 1);
        check("async_rst_bin",   int'(bin),   0);
        check("async_rst_done",  int'(done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("async_rst_no_done", saw_done, 0);
        $display("async reset test done_seen=%0d", saw_done);

        // full sweep with random idle gaps
        for (int v = 0; v < 1024; v++) begin
            logic       th;
            logic [3:0] h, t, o;
            th = (v >= 1000);
            h  = 4'((v / 100) % 10);
            t  = 4'((v / 10) % 10);
            o  = 4'(v % 10);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_conv(th, h, t, o, lat, rbin, rerr, rdy);
            checks++;
            if (rbin !== 10'(v) || rerr !== 1'b0 || lat != 10) begin
                errors++;
                $display("FAIL sweep_%0d: got bin=%0d err=%0d lat=%0d expected bin=%0d err=0 lat=10",
                         v, rbin, rerr, lat, v);
            end else begin
                $display("sweep %0d bin=%0d", v, rbin);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
